// File: rtl/pipe_reg_elastic.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake at both ends.
// Supports bubble collapsing, backpressure stall, synchronous flush and a registered occupancy count.
module pipe_reg_elastic #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             Asynch_clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_d;
    logic [DEPTH-1:0] adv;
    logic [CW-1:0]    v_count;
    logic             accept;
    logic             out_xfer;

    // A stage advances when any stage at or downstream of it is empty, or the output drains.
    always_comb begin
        adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            adv[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                adv[i] = adv[i] | !v_q[j];
            end
        end
    end

    assign in_ready  = adv[0] & !flush;
    assign accept    = in_valid & in_ready;
    assign out_xfer  = v_q[DEPTH-1] & out_ready;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            d_d[i] = d_q[i];
        end

        if (adv[0]) begin
            v_d[0] = accept;
            if (accept) begin
                d_d[0] = in_data;
            end
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end

        // Flush only drops the valid flags; payload registers keep their contents.
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_d[i] = d_q[i];
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({accept, out_xfer})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Asynch_clr) begin
        if (Asynch_clr) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    always_comb begin
        v_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_count = v_count + CW'(v_q[i]);
        end
    end

    occ_matches_valids: assert property (@(posedge CLK) disable iff (Asynch_clr) occ_q == v_count);

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic: a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=16 instance
// share stimulus and are each compared every cycle against a timestamped queue model.
module tb_pipe_reg_elastic;

    logic        CLK = 1'b0;
    logic        Asynch_clr;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic        in_ready0;
    logic        out_valid0;
    logic [7:0]  out_data0;
    logic [2:0]  occ0;
    logic        in_ready1;
    logic        out_valid1;
    logic [15:0] out_data1;
    logic [0:0]  occ1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Each queued word remembers the earliest edge count at which it may sit in the last stage.
    typedef struct {
        logic [15:0] data;
        int          avail;
    } ent_t;

    ent_t mq0[$];
    ent_t mq1[$];

    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        int         exp_occ;
    } vec_t;

    vec_t tbl[8];

    pipe_reg_elastic #(.WIDTH(8), .DEPTH(4)) dut0 (
        .CLK(CLK), .Asynch_clr(Asynch_clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data[7:0]),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    pipe_reg_elastic #(.WIDTH(16), .DEPTH(1)) dut1 (
        .CLK(CLK), .Asynch_clr(Asynch_clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    always #5 CLK = ~CLK;

    function automatic int m_depth(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    function automatic int m_size(input int m);
        return (m == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic ent_t m_head(input int m);
        ent_t e;
        e.data  = '0;
        e.avail = 0;
        if (m == 0 && mq0.size() > 0) e = mq0[0];
        if (m == 1 && mq1.size() > 0) e = mq1[0];
        return e;
    endfunction

    function automatic logic exp_ready(input int m);
        return !flush && (m_size(m) < m_depth(m) || out_ready);
    endfunction

    function automatic logic exp_valid(input int m);
        return (m_size(m) > 0) && (m_head(m).avail <= cyc);
    endfunction

    function automatic logic act_ready(input int m);
        return (m == 0) ? in_ready0 : in_ready1;
    endfunction

    function automatic logic act_valid(input int m);
        return (m == 0) ? out_valid0 : out_valid1;
    endfunction

    function automatic logic [15:0] act_data(input int m);
        return (m == 0) ? {8'h00, out_data0} : out_data1;
    endfunction

    function automatic int act_occ(input int m);
        return (m == 0) ? int'(occ0) : int'(occ1);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic iv, input logic [15:0] din, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Compare both instances against the model halfway through the cycle.
    task automatic sample_model();
        @(negedge CLK);
        for (int m = 0; m < 2; m++) begin
            check_output($sformatf("dut%0d in_ready", m), 32'(act_ready(m)), 32'(exp_ready(m)));
            check_output($sformatf("dut%0d out_valid", m), 32'(act_valid(m)), 32'(exp_valid(m)));
            check_output($sformatf("dut%0d occupancy", m), act_occ(m), m_size(m));
            if (exp_valid(m)) begin
                check_output($sformatf("dut%0d out_data", m), 32'(act_data(m)), 32'(m_head(m).data));
            end
        end
    endtask

    task automatic advance();
        logic acc0, acc1, xf0, xf1;
        ent_t e;
        acc0 = in_valid && exp_ready(0);
        acc1 = in_valid && exp_ready(1);
        xf0  = exp_valid(0) && out_ready;
        xf1  = exp_valid(1) && out_ready;
        @(posedge CLK);
        if (xf0) void'(mq0.pop_front());
        if (xf1) void'(mq1.pop_front());
        if (acc0) begin
            e.data  = {8'h00, in_data[7:0]};
            e.avail = cyc + m_depth(0);
            mq0.push_back(e);
        end
        if (acc1) begin
            e.data  = in_data;
            e.avail = cyc + m_depth(1);
            mq1.push_back(e);
        end
        if (flush) begin
            mq0.delete();
            mq1.delete();
        end
        cyc++;
        #1;
    endtask

    task automatic cycle(input logic iv, input logic [15:0] din, input logic ordy, input logic fl);
        apply_stimulus(iv, din, ordy, fl);
        sample_model();
        advance();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    // Called just after a rising edge; outputs must clear before the next edge arrives.
    task automatic do_reset();
        Asynch_clr = 1'b1;
        #2;
        check_output("async out_valid0", 32'(out_valid0), 0);
        check_output("async out_data0", 32'(out_data0), 0);
        check_output("async occ0", 32'(occ0), 0);
        check_output("async out_valid1", 32'(out_valid1), 0);
        check_output("async out_data1", 32'(out_data1), 0);
        check_output("async occ1", 32'(occ1), 0);
        repeat (3) @(posedge CLK);
        #1;
        check_output("held occ0", 32'(occ0), 0);
        check_output("held out_valid0", 32'(out_valid0), 0);
        mq0.delete();
        mq1.delete();
        Asynch_clr = 1'b0;
    endtask

    initial begin
        int idx;
        tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 2};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

        Asynch_clr = 1'b1;
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        check_output("power-on occ0", 32'(occ0), 0);
        check_output("power-on out_valid0", 32'(out_valid0), 0);
        repeat (2) @(posedge CLK);
        #1;
        Asynch_clr = 1'b0;

        // Latency and throughput vectors into an empty pipe.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(tbl[i].iv, {8'h00, tbl[i].din}, tbl[i].ordy, 1'b0);
            sample_model();
            check_output($sformatf("tbl[%0d] in_ready", i), 32'(in_ready0), 32'(tbl[i].exp_rdy));
            check_output($sformatf("tbl[%0d] out_valid", i), 32'(out_valid0), 32'(tbl[i].exp_ov));
            check_output($sformatf("tbl[%0d] occupancy", i), 32'(occ0), tbl[i].exp_occ);
            if (tbl[i].exp_ov) begin
                check_output($sformatf("tbl[%0d] out_data", i), 32'(out_data0), 32'(tbl[i].exp_od));
            end
            advance();
        end

        // Backpressure: fill while stalled, then release.
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, 16'h00A0 + 16'(idx), 1'b0, 1'b0);
            sample_model();
            if (exp_ready(0)) idx++;
            advance();
        end
        apply_stimulus(1'b1, 16'h00A0 + 16'(idx), 1'b0, 1'b0);
        sample_model();
        check_output("stall accepted", idx, 4);
        check_output("stall in_ready", 32'(in_ready0), 0);
        check_output("stall occupancy", 32'(occ0), 4);
        check_output("stall out_data", 32'(out_data0), 32'h A0);
        advance();
        apply_stimulus(1'b1, 16'h00A0 + 16'(idx), 1'b1, 1'b0);
        sample_model();
        check_output("release in_ready", 32'(in_ready0), 1);
        if (exp_ready(0)) idx++;
        advance();
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(idx < 6, 16'h00A0 + 16'(idx), 1'b1, 1'b0);
            sample_model();
            if (idx < 6 && exp_ready(0)) idx++;
            advance();
        end
        check_output("backpressure all sent", idx, 6);

        // Bubble collapse while stalled.
        cycle(1'b1, 16'h0001, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0002, 1'b0, 1'b0);
        sample_model();
        check_output("bubble in_ready", 32'(in_ready0), 1);
        advance();
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        sample_model();
        check_output("bubble occupancy", 32'(occ0), 2);
        check_output("bubble in_ready after", 32'(in_ready0), 1);
        check_output("bubble head", 32'(out_data0), 32'h01);
        advance();
        drain(6);

        // Flush with three words held and input still offered.
        cycle(1'b1, 16'h0031, 1'b0, 1'b0);
        cycle(1'b1, 16'h0032, 1'b0, 1'b0);
        cycle(1'b1, 16'h0033, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0044, 1'b0, 1'b1);
        sample_model();
        check_output("flush in_ready", 32'(in_ready0), 0);
        advance();
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        sample_model();
        check_output("post-flush occupancy", 32'(occ0), 0);
        check_output("post-flush out_valid", 32'(out_valid0), 0);
        advance();
        drain(5);

        // Full pipe with simultaneous accept and deliver.
        for (int k = 0; k < 4; k++) cycle(1'b1, 16'hB000 + 16'(k), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 16'hC000 + 16'(k), 1'b1, 1'b0);
            sample_model();
            check_output("full occ0", 32'(occ0), 4);
            check_output("full occ1", 32'(occ1), 1);
            check_output("full out_valid0", 32'(out_valid0), 1);
            advance();
        end
        drain(6);

        // Randomised traffic with an asynchronous reset mid-stream.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            cycle(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 20) == 0);
        end
        drain(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the single-stage 8-bit async-clear D register.
- A WIDTH-bit, DEPTH-stage elastic pipeline register: each stage holds data plus a valid flag, with a valid/ready handshake at both ends.
- Adds bubble collapsing, backpressure stall, synchronous flush and an occupancy count.
- Used between datapath blocks wherever a registered, stallable delay of DEPTH cycles is required.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- Asynch_clr  in  1  reset, asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous clear of all valid flags.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  stage DEPTH-1 holds a valid word.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  contents of stage DEPTH-1.
- occupancy  out  CW  number of valid stages, 0..DEPTH.

Behaviour:
- Reset: while Asynch_clr=1, all stage valids=0, all stage data=0, occupancy=0, out_valid=0, out_data=0. Asynch_clr overrides CLK and flush. Deassertion is effective at the next rising edge.
- Stage index 0 is the input side; DEPTH-1 is the output side. v[i] and d[i] are the stage valid and data.
- Advance rule, evaluated combinationally each cycle:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
  - A stage may load whenever it is empty or its contents move on (bubble collapsing).
- in_ready = adv[0] & !flush.
- Accept: in_valid & in_ready.
- Output transfer: out_valid & out_ready.
- Per rising edge, with flush=0:
  - If adv[i] holds, then v[i] <= v[i-1] and d[i] <= d[i-1] (for i=0 the source is in_valid/in_data, gated by in_ready).
  - Otherwise the stage holds.
  - d[i] loads only when the source valid is 1. Data in bubbles retains its old value.
- out_valid = v[DEPTH-1] and out_data = d[DEPTH-1], both taken directly from registers with no combinational path from in_*.
- in_ready is combinational from out_ready, flush and the valids. This ready chain is accepted at DEPTH <= 8.
- Latency: into an empty pipe with out_ready=1, a word accepted at edge k is presented on out_valid after edge k+DEPTH-1, i.e. DEPTH cycles from in handshake to out handshake.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Stall: out_ready=0 holds out_data stable while out_valid=1. Upstream stages continue to fill until all DEPTH are valid, then in_ready=0.
- Full with out_ready=1: the output transfer and an input accept happen in the same cycle; occupancy is unchanged.
- Flush: at an edge with flush=1, all v[i] <= 0 and data is retained.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - An output transfer already presented in the flush cycle (out_valid & out_ready) counts as delivered.
  - The word is then discarded with the rest of the pipe.
- occupancy is a registered count, updated each edge:
  - +1 on accept, -1 on output transfer, both means no change.
  - Forced to 0 on flush or reset.
  - Must always equal the popcount of v[]; a mismatch is an assertion failure.
- Asynch_clr asserted mid-stream: in-flight words are lost and no partial state survives. After release, the first accept starts at stage 0.
- DEPTH=1 degenerates to a single registered slot with backpressure: in_ready = !v[0] | out_ready.
- Words never reorder, duplicate or drop except via flush or reset.

Test Plan:
- Reset: hold Asynch_clr=1 for 3 cycles mid-burst (WIDTH=8, DEPTH=4) -> out_valid=0, out_data=8'h00, occupancy=0 within the same cycle, without waiting for CLK.
- Latency/throughput: out_ready=1; accept 8'h11,8'h22,8'h33 on consecutive cycles -> out_valid first high 4 cycles after the 8'h11 handshake; words exit on consecutive cycles in order; occupancy peaks at 3.
- Backpressure: out_ready=0; drive in_valid=1 with 8'hA0..8'hA5 -> first 4 accepted, in_ready=0 after the 4th, occupancy=4, out_data=8'hA0 stable. Release out_ready -> 8'hA0..8'hA5 exit in order and in_ready returns the same cycle.
- Bubble collapse: accept 8'h01, idle 2 cycles, accept 8'h02, with out_ready=0 -> both end in stages 3 and 2, occupancy=2, in_ready stays 1.
- Flush: pipe holding 3 words with in_valid=1; assert flush for 1 cycle -> in_ready=0 that cycle, occupancy=0 and out_valid=0 next cycle, the in_data presented during flush is not accepted.
- Full simultaneous: full pipe, out_ready=1 and in_valid=1 each cycle for 10 cycles -> occupancy stays 4, one word out per cycle, a scoreboard matches all words; repeat at DEPTH=1, WIDTH=16.
